// File: rtl/pc_unit.sv
// Program counter unit: holds the fetch address, steers it on branches,
// and counts accepted fetches. A small BOOT/RUN/BUBBLE FSM gates fetch_valid.
module pc_unit #(
    parameter logic [63:0] RESET_PC = 64'h0000000000000000,
    parameter int          COUNT_EN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        br_taken,
    input  logic [63:0] br_offset,
    input  logic        br_reg,
    input  logic [63:0] reg_target,
    output logic [63:0] pc,
    output logic [63:0] pc_plus4,
    output logic        fetch_valid,
    output logic [63:0] fetch_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2
    } state_t;

    state_t      state, state_nx;
    logic [63:0] pc_nx;
    logic [63:0] target;
    logic [63:0] offset_bytes;
    logic        redirect;
    logic        accept;
    logic        count_inc;

    // Fetch handshake: a fetch transfers on a cycle where fetch_valid and
    // imem_ready are both high and stall is low; pc holds until it transfers.
    // A redirect in the same cycle overrides the transfer and is not counted.
    assign fetch_valid  = (state == RUN);
    assign accept       = fetch_valid & imem_ready & ~stall;
    assign redirect     = br_reg | br_taken;
    assign offset_bytes = br_offset << 2;
    // BR wins over a PC-relative branch when both arrive together.
    assign target       = br_reg ? (reg_target & ~64'h3) : (pc + offset_bytes);
    assign pc_plus4     = pc + 64'd4;
    assign dbg_state    = state;

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        count_inc = 1'b0;
        case (state)
            BOOT: begin
                if (redirect) begin
                    pc_nx    = target;
                    state_nx = BUBBLE;
                end else begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_nx    = target;
                    state_nx = BUBBLE;
                end else if (accept) begin
                    pc_nx     = pc_plus4;
                    count_inc = 1'b1;
                end
            end
            BUBBLE: begin
                if (redirect) begin
                    pc_nx = target;
                end else begin
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    generate
        if (COUNT_EN != 0) begin : g_count
            always_ff @(posedge clk) begin
                if (reset) begin
                    fetch_count <= 64'd0;
                end else if (count_inc) begin
                    fetch_count <= fetch_count + 64'd1;
                end
            end
        end else begin : g_no_count
            assign fetch_count = 64'd0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized checks of pc_unit against a behavioural model
// of the fetch address sequence.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        imem_ready;
    logic        br_taken;
    logic [63:0] br_offset;
    logic        br_reg;
    logic [63:0] reg_target;
    logic [63:0] pc;
    logic [63:0] pc_plus4;
    logic        fetch_valid;
    logic [63:0] fetch_count;
    logic [1:0]  dbg_state;

    localparam logic [63:0] RST_PC = 64'h0;
    localparam int M_BOOT   = 0;
    localparam int M_RUN    = 1;
    localparam int M_BUBBLE = 2;

    int checks = 0;
    int errors = 0;

    // Model: fetch address, phase and number of fetches handed to memory.
    logic [63:0] m_pc;
    int          m_phase;
    logic [63:0] m_cnt;

    pc_unit #(.RESET_PC(RST_PC), .COUNT_EN(1)) dut (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .br_taken(br_taken), .br_offset(br_offset), .br_reg(br_reg),
        .reg_target(reg_target), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .fetch_count(fetch_count),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 64'd4);
        chk({tag, ".fetch_valid"}, {63'd0, fetch_valid}, (m_phase == M_RUN) ? 64'd1 : 64'd0);
        chk({tag, ".fetch_count"}, fetch_count, m_cnt);
        chk({tag, ".state"}, {62'd0, dbg_state}, 64'(m_phase));
    endtask

    // Apply inputs for one cycle, check current outputs, advance model and clock.
    task automatic step(input string tag, input logic r, input logic s, input logic ir,
                        input logic bt, input logic [63:0] bo,
                        input logic br, input logic [63:0] rt);
        logic [63:0] tgt;
        reset = r; stall = s; imem_ready = ir;
        br_taken = bt; br_offset = bo; br_reg = br; reg_target = rt;
        check_model(tag);
        if (br) tgt = rt - (rt % 64'd4);
        else    tgt = m_pc + bo * 64'd4;
        if (r) begin
            m_pc = RST_PC; m_phase = M_BOOT; m_cnt = 64'd0;
        end else if (br || bt) begin
            m_pc = tgt; m_phase = M_BUBBLE;
        end else if (m_phase == M_RUN) begin
            if (ir && !s) begin
                m_pc = m_pc + 64'd4; m_cnt = m_cnt + 64'd1;
            end
        end else begin
            m_phase = M_RUN;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b0;
        br_taken = 1'b0; br_offset = 64'd0; br_reg = 1'b0; reg_target = 64'd0;
        m_pc = RST_PC; m_phase = M_BOOT; m_cnt = 64'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset held with arbitrary activity on the other inputs.
        for (int i = 0; i < 3; i++)
            step("rst_hold", 1'b1, 1'($urandom), 1'($urandom), 1'b1,
                 {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom});

        // Free run from reset.
        idle("free0");
        chk("free_c1_fv", {63'd0, fetch_valid}, 64'd1);
        chk("free_c1_pc", pc, 64'd0);
        idle("free1");
        idle("free2");
        chk("free_pc8", pc, 64'd8);
        chk("free_cnt2", fetch_count, 64'd2);

        // Stall then memory backpressure.
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
        for (int i = 0; i < 2; i++) step("bp", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        chk("stall_pc", pc, 64'd8);
        chk("stall_cnt", fetch_count, 64'd2);

        // PC-relative branch backwards from 0x100.
        step("go100", 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 64'h100);
        idle("go100_bub");
        chk("br_start_pc", pc, 64'h100);
        step("br", 1'b0, 1'b0, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0, 64'd0);
        chk("br_pc", pc, 64'hF8);
        chk("br_bubble_fv", {63'd0, fetch_valid}, 64'd0);
        step("br_bub", 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        chk("br_run_fv", {63'd0, fetch_valid}, 64'd1);

        // Register branch beats PC-relative branch and stall.
        step("prio", 1'b0, 1'b1, 1'b1, 1'b1, 64'd3, 1'b1, 64'h0000123FAAAA0007);
        chk("prio_pc", pc, 64'h0000123FAAAA0004);
        idle("prio_bub");

        // Wrap at top of address space.
        step("gotop", 1'b0, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF);
        idle("gotop_bub");
        chk("top_pc", pc, 64'hFFFFFFFFFFFFFFFC);
        chk("top_plus4", pc_plus4, 64'd0);
        idle("wrap");
        chk("wrap_pc", pc, 64'd0);
        chk("wrap_plus4", pc_plus4, 64'd4);

        // Reset during a bubble, with another redirect pending.
        step("br2", 1'b0, 1'b0, 1'b1, 1'b1, 64'd5, 1'b0, 64'd0);
        step("rst_mid", 1'b1, 1'b0, 1'b1, 1'b1, 64'd9, 1'b1, 64'h4444);
        chk("rst_mid_pc", pc, RST_PC);
        chk("rst_mid_cnt", fetch_count, 64'd0);
        chk("rst_mid_state", {62'd0, dbg_state}, 64'(M_BOOT));
        chk("rst_mid_fv", {63'd0, fetch_valid}, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, bt, br;
            r  = ($urandom_range(0, 49) == 0);
            bt = ($urandom_range(0, 9) == 0);
            br = ($urandom_range(0, 14) == 0);
            step("rand", r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), bt,
                 64'($signed(32'($urandom_range(0, 255)) - 32'sd128)), br,
                 {$urandom, $urandom});
        end
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000000000000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter COUNT_EN, default 1, meaning the fetch counter is enabled (0 ties fetch_count to zero).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  pipeline hold request from downstream.
REQ-006 SHALL have port imem_ready  input  1  instruction memory accepts the address presented on pc this cycle.
REQ-007 SHALL have port br_taken  input  1  resolved PC-relative branch (B, taken CBZ or B.cond).
REQ-008 SHALL have port br_offset  input  64  sign-extended branch word offset, not yet shifted.
REQ-009 SHALL have port br_reg  input  1  register-indirect branch (BR).
REQ-010 SHALL have port reg_target  input  64  BR target address.
REQ-011 SHALL have port pc  output  64  current fetch address.
REQ-012 SHALL have port pc_plus4  output  64  combinational pc + 4, for link-register write.
REQ-013 SHALL have port fetch_valid  output  1  pc is a valid fetch request this cycle.
REQ-014 SHALL have port fetch_count  output  64  number of accepted fetches since reset.

Function
REQ-015 SHALL implement a three-state FSM: BOOT, RUN, BUBBLE.
REQ-016 SHALL define accept = fetch_valid AND imem_ready AND NOT stall.
REQ-017 SHALL define redirect = br_reg OR br_taken; redirect has priority over stall and imem_ready.
REQ-018 SHALL, in BOOT, hold fetch_valid=0 and go to RUN next cycle unless redirect, then to BUBBLE.
REQ-019 SHALL, in RUN, drive fetch_valid=1; on redirect load target and go to BUBBLE; on accept load pc+4 and stay; otherwise hold pc.
REQ-020 SHALL, in BUBBLE, drive fetch_valid=0, hold pc, and go to RUN next cycle unless a new redirect occurs, which reloads the target and stays in BUBBLE.
REQ-021 SHALL compute the branch target as pc + (br_offset << 2), modulo 2^64, with no overflow flag.
REQ-022 SHALL use reg_target with bits [1:0] forced to 0 as the BR target.
REQ-023 SHALL give br_reg priority over br_taken when both are asserted.
REQ-024 SHALL compute pc + 4 modulo 2^64, so 64'hFFFFFFFFFFFFFFFC wraps to 0.
REQ-025 SHALL increment fetch_count by 1 on each accept cycle only, wrapping at 2^64.
REQ-026 SHALL NOT count a redirect cycle as an accept, even when imem_ready=1.
REQ-027 SHALL make pc_plus4 combinational from pc; all other outputs are registered or derived from the FSM state.

Reset
REQ-028 SHALL, on reset high at a clock edge, set pc=RESET_PC, state=BOOT, fetch_valid=0, fetch_count=0, regardless of all other inputs.
REQ-029 SHALL let reset asserted mid-redirect or mid-stall discard the pending target.
REQ-030 SHALL hold reset values for as long as reset is held high.

Verification
REQ-031 SHALL verify free-run: reset, then imem_ready=1, stall=0 for 4 cycles -> fetch_valid 0,1,1,1; pc 0,0,4,8; fetch_count reaches 2 after the third cycle.
REQ-032 SHALL verify stall/backpressure: pc=8 with stall=1 for 3 cycles, then imem_ready=0 for 2 cycles -> pc stays 8 and fetch_count is unchanged.
REQ-033 SHALL verify branch: pc=64'h100, br_taken=1, br_offset=64'hFFFFFFFFFFFFFFFE -> next pc=64'hF8, one BUBBLE cycle with fetch_valid=0, then RUN.
REQ-034 SHALL verify priority: br_reg=1, reg_target=64'h0000123FAAAA0007, br_taken=1, stall=1 -> next pc=64'h0000123FAAAA0004.
REQ-035 SHALL verify wrap: pc=64'hFFFFFFFFFFFFFFFC, accept -> pc=0 and pc_plus4=4.
REQ-036 SHALL verify reset mid-operation: reset asserted during BUBBLE after a branch -> pc=RESET_PC, fetch_count=0, state BOOT.
